ttt_game_ctrl: RTL and testbench
================================

# ttt_game_ctrl

Turn sequencer and move arbiter for the two-player tic-tac-toe game. Accepts move requests from both players, grants only the player whose turn it is, and writes legal moves into the 9-cell board register. Evaluates win and draw after each move and holds the result until a new game starts. Sits between the player input front-ends and the board display/status logic; its board output feeds the board-full and display logic directly.

## Interface
- START_PLAYER, default 0: player who moves first after reset/new_game (0 = P1, 1 = P2).
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high; same effect as new_game.
- new_game  in  1  synchronous clear of board and game state.
- p1_valid  in  1  P1 move request.
- p1_pos  in  4  P1 target cell, 1..9 (row-major, 1 = top-left).
- p2_valid  in  1  P2 move request.
- p2_pos  in  4  P2 target cell, 1..9.
- board  out  18  cell k at bits [2k-1:2k-2]; 00 empty, 01 P1, 10 P2 (11 never produced).
- turn  out  1  player to move (0 = P1, 1 = P2); valid in P1_TURN/P2_TURN.
- accept  out  1  one-cycle pulse: a move was written.
- illegal  out  1  one-cycle pulse: current player's request was rejected.
- move_count  out  4  number of cells filled, 0..9.
- game_over  out  1  high in OVER.
- winner  out  2  00 none/draw, 01 P1, 10 P2; meaningful only while game_over = 1.

## Operation
- States: TURN (current player in turn register), EVAL, OVER.
- Reset/new_game: board = 0, move_count = 0, turn = START_PLAYER, accept = illegal = 0, game_over = 0, winner = 00, state TURN.
- TURN: only the current player's valid/pos are sampled; the other player's request is ignored with no pulse.
  - Legal: pos in 1..9 and the cell is 00. Write the mover's code to the cell, increment move_count, pulse accept, go to EVAL.
  - pos = 0 or pos > 9, or the cell is occupied: pulse illegal, board unchanged, stay in TURN.
- EVAL (exactly one cycle; all requests ignored): test the 8 lines (3 rows, 3 columns, 2 diagonals) for three cells equal to the mover's code.
  - Win: go to OVER, winner = mover.
  - Else if move_count = 9: go to OVER, winner = 00.
  - Else: toggle turn and return to TURN.
  - Win has priority over draw on the ninth move.
- OVER: board, winner and move_count frozen; all requests ignored; exits only via reset/new_game.
- new_game has priority over any simultaneous request or state transition. The request in that cycle is dropped.
- move_count never wraps; it saturates at 9 by construction (OVER is reached at 9).

## Timing
- Request sampled at edge N (state TURN). Board, move_count and accept update at N+1; state EVAL during cycle N+1.
- turn, game_over and winner update at edge N+2.
- Minimum 2 cycles between successive accepted moves.
- Illegal requests: illegal is high for the cycle after the sampling edge. A held request re-pulses illegal every cycle.
- A legal request held valid across EVAL is not re-sampled. After the turn toggles, the other player's request is the one considered.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package ttt_pkg holds:
  - cell codes EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10;
  - state encoding TURN/EVAL/OVER;
  - winner codes;
  - the 8-entry win-line cell-index table.
- Sub-module ttt_line_check: combinational; inputs board[17:0] and mark[1:0]; output win when any line is all mark. Instantiated once, driven with the mover's code.

## Test plan
- Reset, then p1_valid = 1, p1_pos = 5 -> accept pulse next cycle; board[9:8] = 01; move_count = 1; turn = 1 two cycles after the request.
- In P1's turn, p2_valid = 1, p2_pos = 1 -> no accept, no illegal, board unchanged. Then P1 plays cell 5 and P2 plays cell 5 -> illegal pulse, board[9:8] stays 01.
- P1 plays 1, 2, 3 interleaved with P2 playing 4, 5 -> after P1's third move: game_over = 1, winner = 01, move_count = 5. Further requests are ignored.
- Full-board sequence P1:1,3,4,8,9 / P2:2,5,6,7 -> game_over = 1, winner = 00, move_count = 9.
- p1_pos = 0 and p1_pos = 12 -> illegal pulse each time, move_count unchanged.
- new_game asserted in the same cycle as a legal request, and separately during EVAL and OVER -> next cycle: board = 0, move_count = 0, turn = START_PLAYER, game_over = 0, no accept. Repeat with START_PLAYER = 1.

Source files
------------

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the tic-tac-toe turn controller.
// Holds the cell codes, winner codes, controller state encoding, the table
// of the eight winning lines (as 0-based cell indices), and small helpers
// for reading a cell out of the packed 18-bit board.
package ttt_pkg;

    // Cell codes as stored in the board register.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    // Winner codes; the draw outcome shares the "none" code.
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Controller states.
    typedef enum logic [1:0] {
        TURN = 2'b00,
        EVAL = 2'b01,
        OVER = 2'b10
    } state_t;

    localparam int NUM_LINES = 8;

    // Winning lines as 0-based cell indices (cell k of the board is index k-1).
    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},   // top row
        '{4'd3, 4'd4, 4'd5},   // middle row
        '{4'd6, 4'd7, 4'd8},   // bottom row
        '{4'd0, 4'd3, 4'd6},   // left column
        '{4'd1, 4'd4, 4'd7},   // middle column
        '{4'd2, 4'd5, 4'd8},   // right column
        '{4'd0, 4'd4, 4'd8},   // main diagonal
        '{4'd2, 4'd4, 4'd6}    // anti diagonal
    };

    // Two-bit code of the cell at 0-based index idx.
    function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
        return board[{idx, 1'b0} +: 2];
    endfunction

    // Cell code written by the player whose turn bit is given.
    function automatic logic [1:0] mark_of(input logic turn);
        return turn ? P2 : P1;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// ttt_line_check: combinational win detector.
// Ports:
//   i_board [17:0]  packed board, cell k at bits [2k-1:2k-2]
//   i_mark  [1:0]   cell code to look for
//   o_win           high when any row, column or diagonal is all i_mark
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [17:0] i_board,
    input  logic [1:0]  i_mark,
    output logic        o_win
);

    // OR together the eight line matches.
    always_comb begin
        o_win = 1'b0;
        for (int l = 0; l < NUM_LINES; l++) begin
            if ((cell_at(i_board, WIN_LINES[l][0]) == i_mark) &&
                (cell_at(i_board, WIN_LINES[l][1]) == i_mark) &&
                (cell_at(i_board, WIN_LINES[l][2]) == i_mark)) begin
                o_win = 1'b1;
            end else begin
                o_win = o_win;
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: turn sequencer and move arbiter for two-player tic-tac-toe.
// Grants only the player whose turn it is, writes legal moves to the board,
// evaluates win/draw one cycle after each accepted move, and freezes in OVER
// until reset or new game.
// Ports:
//   i_clock                      system clock, rising edge
//   i_reset, i_new_game          synchronous clears (same effect)
//   i_p1_valid/i_p1_pos [3:0]    P1 move request, cell 1..9
//   i_p2_valid/i_p2_pos [3:0]    P2 move request, cell 1..9
//   o_board [17:0]               cell k at [2k-1:2k-2]; 00 empty, 01 P1, 10 P2
//   o_turn                       player to move (0 = P1, 1 = P2)
//   o_accept / o_illegal         one-cycle pulses for written / rejected moves
//   o_move_count [3:0]           cells filled, 0..9
//   o_game_over, o_winner [1:0]  result, held in OVER
// All outputs come straight from registers.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic START_PLAYER = 1'b0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_new_game,
    input  logic        i_p1_valid,
    input  logic [3:0]  i_p1_pos,
    input  logic        i_p2_valid,
    input  logic [3:0]  i_p2_pos,
    output logic [17:0] o_board,
    output logic        o_turn,
    output logic        o_accept,
    output logic        o_illegal,
    output logic [3:0]  o_move_count,
    output logic        o_game_over,
    output logic [1:0]  o_winner
);

    state_t      r_state;
    logic        r_turn;
    logic [17:0] r_board;
    logic [3:0]  r_move_count;
    logic        r_accept;
    logic        r_illegal;
    logic        r_game_over;
    logic [1:0]  r_winner;

    state_t      w_state_next;
    logic        w_turn_next;
    logic [17:0] w_board_next;
    logic [3:0]  w_move_count_next;
    logic        w_accept_next;
    logic        w_illegal_next;
    logic        w_game_over_next;
    logic [1:0]  w_winner_next;

    logic        w_req_valid;
    logic [3:0]  w_req_pos;
    logic [3:0]  w_cell;
    logic        w_pos_ok;
    logic        w_cell_free;
    logic [1:0]  w_mark;
    logic        w_win;

    // Only the current player's request is considered.
    assign w_req_valid = r_turn ? i_p2_valid : i_p1_valid;
    assign w_req_pos   = r_turn ? i_p2_pos   : i_p1_pos;
    assign w_cell      = w_req_pos - 4'd1;
    assign w_pos_ok    = (w_req_pos >= 4'd1) && (w_req_pos <= 4'd9);
    // Out-of-range positions may read garbage here; w_pos_ok masks that.
    assign w_cell_free = (cell_at(r_board, w_cell) == EMPTY);
    // The turn bit still names the mover during EVAL, so the mark is valid there.
    assign w_mark      = mark_of(r_turn);

    ttt_line_check u_line_check (
        .i_board (r_board),
        .i_mark  (w_mark),
        .o_win   (w_win)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_next      = r_state;
        w_turn_next       = r_turn;
        w_board_next      = r_board;
        w_move_count_next = r_move_count;
        w_accept_next     = 1'b0;
        w_illegal_next    = 1'b0;
        w_game_over_next  = r_game_over;
        w_winner_next     = r_winner;
        case (r_state)
            TURN: begin
                if (w_req_valid) begin
                    if (w_pos_ok && w_cell_free) begin
                        w_board_next[{w_cell, 1'b0} +: 2] = w_mark;
                        w_move_count_next = r_move_count + 4'd1;
                        w_accept_next     = 1'b1;
                        w_state_next      = EVAL;
                    end else begin
                        w_illegal_next = 1'b1;
                    end
                end else begin
                    w_illegal_next = 1'b0;
                end
            end
            EVAL: begin
                // Win is checked first so a ninth-move win is not a draw.
                if (w_win) begin
                    w_state_next     = OVER;
                    w_game_over_next = 1'b1;
                    w_winner_next    = r_turn ? WIN_P2 : WIN_P1;
                end else if (r_move_count == 4'd9) begin
                    w_state_next     = OVER;
                    w_game_over_next = 1'b1;
                    w_winner_next    = WIN_NONE;
                end else begin
                    w_turn_next  = ~r_turn;
                    w_state_next = TURN;
                end
            end
            OVER: begin
                w_state_next = OVER;
            end
            default: begin
                w_state_next = TURN;
            end
        endcase
    end

    // State and output registers; reset/new_game override everything.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_new_game) begin
            r_state      <= TURN;
            r_turn       <= START_PLAYER;
            r_board      <= 18'd0;
            r_move_count <= 4'd0;
            r_accept     <= 1'b0;
            r_illegal    <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= WIN_NONE;
        end else begin
            r_state      <= w_state_next;
            r_turn       <= w_turn_next;
            r_board      <= w_board_next;
            r_move_count <= w_move_count_next;
            r_accept     <= w_accept_next;
            r_illegal    <= w_illegal_next;
            r_game_over  <= w_game_over_next;
            r_winner     <= w_winner_next;
        end
    end

    assign o_board      = r_board;
    assign o_turn       = r_turn;
    assign o_accept     = r_accept;
    assign o_illegal    = r_illegal;
    assign o_move_count = r_move_count;
    assign o_game_over  = r_game_over;
    assign o_winner     = r_winner;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench: two instances (first player P1 and first player P2) share
// the same stimulus; a game-rules model predicts each cycle's outputs and a
// separate monitor compares them one cycle after every driven input.
module tb_ttt_game_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, new_game, p1_valid, p2_valid;
    logic [3:0] p1_pos, p2_pos;

    logic [17:0] board   [2];
    logic        turn    [2];
    logic        accept  [2];
    logic        illegal [2];
    logic [3:0]  cnt     [2];
    logic        over    [2];
    logic [1:0]  winner  [2];

    ttt_game_ctrl #(.START_PLAYER(1'b0)) dut0 (
        .i_clock(clk), .i_reset(reset), .i_new_game(new_game),
        .i_p1_valid(p1_valid), .i_p1_pos(p1_pos),
        .i_p2_valid(p2_valid), .i_p2_pos(p2_pos),
        .o_board(board[0]), .o_turn(turn[0]), .o_accept(accept[0]),
        .o_illegal(illegal[0]), .o_move_count(cnt[0]),
        .o_game_over(over[0]), .o_winner(winner[0])
    );

    ttt_game_ctrl #(.START_PLAYER(1'b1)) dut1 (
        .i_clock(clk), .i_reset(reset), .i_new_game(new_game),
        .i_p1_valid(p1_valid), .i_p1_pos(p1_pos),
        .i_p2_valid(p2_valid), .i_p2_pos(p2_pos),
        .o_board(board[1]), .o_turn(turn[1]), .o_accept(accept[1]),
        .o_illegal(illegal[1]), .o_move_count(cnt[1]),
        .o_game_over(over[1]), .o_winner(winner[1])
    );

    typedef struct packed {
        logic [17:0] board;
        logic        turn;
        logic        accept;
        logic        illegal;
        logic [3:0]  cnt;
        logic        over;
        logic [1:0]  winner;
    } out_t;

    out_t expq0[$];
    out_t expq1[$];

    int total = 0;
    int bad   = 0;

    // Reference model: cells hold 0 empty, 1 P1, 2 P2; phase 0 play, 1 judge, 2 finished.
    int m_cell  [2][9];
    int m_phase [2];
    int m_turn  [2];
    int m_count [2];
    int m_win   [2];
    int m_acc   [2];
    int m_ill   [2];

    function automatic bit has_line(int inst, int who);
        for (int r = 0; r < 3; r++)
            if (m_cell[inst][3*r] == who && m_cell[inst][3*r+1] == who && m_cell[inst][3*r+2] == who) return 1'b1;
        for (int c = 0; c < 3; c++)
            if (m_cell[inst][c] == who && m_cell[inst][c+3] == who && m_cell[inst][c+6] == who) return 1'b1;
        if (m_cell[inst][0] == who && m_cell[inst][4] == who && m_cell[inst][8] == who) return 1'b1;
        if (m_cell[inst][2] == who && m_cell[inst][4] == who && m_cell[inst][6] == who) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(int inst, bit clr, bit v1, int p1, bit v2, int p2);
        bit v;
        int p;
        m_acc[inst] = 0;
        m_ill[inst] = 0;
        if (clr) begin
            for (int k = 0; k < 9; k++) m_cell[inst][k] = 0;
            m_phase[inst] = 0;
            m_turn[inst]  = inst;
            m_count[inst] = 0;
            m_win[inst]   = 0;
        end else if (m_phase[inst] == 0) begin
            v = (m_turn[inst] == 1) ? v2 : v1;
            p = (m_turn[inst] == 1) ? p2 : p1;
            if (v) begin
                if (p >= 1 && p <= 9 && m_cell[inst][p-1] == 0) begin
                    m_cell[inst][p-1] = m_turn[inst] + 1;
                    m_count[inst]++;
                    m_acc[inst]   = 1;
                    m_phase[inst] = 1;
                end else begin
                    m_ill[inst] = 1;
                end
            end
        end else if (m_phase[inst] == 1) begin
            if (has_line(inst, m_turn[inst] + 1)) begin
                m_phase[inst] = 2;
                m_win[inst]   = m_turn[inst] + 1;
            end else if (m_count[inst] == 9) begin
                m_phase[inst] = 2;
                m_win[inst]   = 0;
            end else begin
                m_turn[inst]  = 1 - m_turn[inst];
                m_phase[inst] = 0;
            end
        end
    endtask

    function automatic out_t expect_of(int inst);
        out_t e;
        e.board = '0;
        for (int k = 0; k < 9; k++) e.board[2*k +: 2] = 2'(m_cell[inst][k]);
        e.turn    = 1'(m_turn[inst]);
        e.accept  = 1'(m_acc[inst]);
        e.illegal = 1'(m_ill[inst]);
        e.cnt     = 4'(m_count[inst]);
        e.over    = (m_phase[inst] == 2);
        e.winner  = 2'(m_win[inst]);
        return e;
    endfunction

    task automatic step(bit rst, bit ng, bit v1, int p1, bit v2, int p2);
        @(negedge clk);
        reset    = rst;
        new_game = ng;
        p1_valid = v1;
        p1_pos   = 4'(p1);
        p2_valid = v2;
        p2_pos   = 4'(p2);
        model_step(0, rst | ng, v1, p1, v2, p2);
        model_step(1, rst | ng, v1, p1, v2, p2);
        expq0.push_back(expect_of(0));
        expq1.push_back(expect_of(1));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic mv1(int p);
        step(1'b0, 1'b0, 1'b1, p, 1'b0, 0);
        idle();
    endtask

    task automatic mv2(int p);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, p);
        idle();
    endtask

    task automatic chk(string name, int inst, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %0h want %0h", name, inst, $time, got, want);
        end
    endtask

    task automatic compare(int inst, out_t e);
        chk("board",      inst, int'(board[inst]),   int'(e.board));
        chk("turn",       inst, int'(turn[inst]),    int'(e.turn));
        chk("accept",     inst, int'(accept[inst]),  int'(e.accept));
        chk("illegal",    inst, int'(illegal[inst]), int'(e.illegal));
        chk("move_count", inst, int'(cnt[inst]),     int'(e.cnt));
        chk("game_over",  inst, int'(over[inst]),    int'(e.over));
        chk("winner",     inst, int'(winner[inst]),  int'(e.winner));
    endtask

    // Monitor: one expectation per driven cycle, checked just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq0.size() > 0) compare(0, expq0.pop_front());
            if (expq1.size() > 0) compare(1, expq1.pop_front());
        end
    end

    // Stimulus.
    initial begin
        int pa, pb;
        reset = 1'b1; new_game = 1'b0;
        p1_valid = 1'b0; p1_pos = 4'd0; p2_valid = 1'b0; p2_pos = 4'd0;

        // Reset, wrong-player request, first move, occupied cell, bad positions.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1);
        idle();
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        mv1(5);
        mv2(5);
        mv2(3);
        mv1(0);
        mv1(12);
        step(1'b0, 1'b0, 1'b1, 15, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 15, 1'b0, 0);
        idle();

        // P1 wins on the top row; later requests ignored.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        mv1(1); mv2(4); mv1(2); mv2(5); mv1(3);
        mv1(7); mv2(7);

        // new_game during OVER.
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0);

        // Full board, no winner.
        mv1(1); mv2(2); mv1(3); mv2(5); mv1(4); mv2(6); mv1(8); mv2(7); mv1(9);
        idle();

        // new_game with a legal request in the same cycle, then during EVAL.
        step(1'b0, 1'b1, 1'b1, 5, 1'b1, 5);
        step(1'b0, 1'b0, 1'b1, 5, 1'b1, 5);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 2, 1'b1, 2);

        // Randomized play with occasional clears.
        for (int i = 0; i < 4000; i++) begin
            pa = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 9);
            pb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 9);
            step($urandom_range(0, 399) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 9) < 6, pa, $urandom_range(0, 9) < 6, pb);
        end
        idle();

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", 0, expq0.size() + expq1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
